// File: rtl/crypto_request_sequencer.sv
// crypto_request_sequencer: buffers host bytes in a small FIFO and runs one accelerator
// start/done transaction per byte, returning results in order. Define CRS_TIMEOUT_EN for the WAIT_DONE abort timer.
//
// state     | meaning
// IDLE      | waiting for a queued byte (output slot is free here)
// ISSUE     | acc_start pulse for the popped byte
// WAIT_DONE | waiting for acc_done (bounded when CRS_TIMEOUT_EN)
// WAIT_CLR  | result captured, waiting for acc_done to drop
// OUTPUT    | result presented on m_valid/m_data
module crypto_request_sequencer #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  input  logic [7:0]  key,
  input  logic        encrypt,
  output logic [7:0]  acc_data_in,
  output logic [7:0]  acc_key,
  output logic        acc_encrypt,
  output logic        acc_start,
  input  logic [7:0]  acc_data_out,
  input  logic        acc_done,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [7:0]  m_data,
  output logic [15:0] byte_count,
  output logic        timeout_err
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ISSUE     = 3'd1;
  localparam logic [2:0] ST_WAIT_DONE = 3'd2;
  localparam logic [2:0] ST_WAIT_CLR  = 3'd3;
  localparam logic [2:0] ST_OUTPUT    = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       acc_data_q, acc_data_d;
  logic [7:0]       acc_key_q, acc_key_d;
  logic             acc_enc_q, acc_enc_d;
  logic [7:0]       m_data_q, m_data_d;
  logic [15:0]      byte_count_q, byte_count_d;
  logic             push, pop, fifo_empty;
  logic [7:0]       head;

`ifdef CRS_TIMEOUT_EN
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             timeout_err_q, timeout_err_d;
`endif

  assign fifo_empty = (count_q == '0);
  assign s_ready    = (count_q != FULL_CNT);
  assign push       = s_valid && s_ready;
  assign pop        = (state_q == ST_IDLE) && !fifo_empty;
  assign head       = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    acc_data_d   = acc_data_q;
    acc_key_d    = acc_key_q;
    acc_enc_d    = acc_enc_q;
    m_data_d     = m_data_q;
    byte_count_d = byte_count_q;
`ifdef CRS_TIMEOUT_EN
    tmr_d         = tmr_q;
    timeout_err_d = timeout_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          acc_data_d = head;
          acc_key_d  = key;
          acc_enc_d  = encrypt;
          // zero bytes pass straight through without touching the accelerator
          if (head == 8'h00) begin
            m_data_d = 8'h00;
            state_d  = ST_OUTPUT;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT_DONE;
`ifdef CRS_TIMEOUT_EN
        tmr_d = TMR_LOAD;
`endif
      end
      ST_WAIT_DONE: begin
        if (acc_done) begin
          m_data_d = acc_data_out;
          state_d  = ST_WAIT_CLR;
        end
`ifdef CRS_TIMEOUT_EN
        else if (tmr_q == '0) begin
          timeout_err_d = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
`endif
      end
      ST_WAIT_CLR: begin
        if (!acc_done) state_d = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        if (m_ready) begin
          byte_count_d = byte_count_q + 16'd1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      acc_data_q   <= 8'h00;
      acc_key_q    <= 8'h00;
      acc_enc_q    <= 1'b0;
      m_data_q     <= 8'h00;
      byte_count_q <= 16'h0000;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      acc_data_q   <= acc_data_d;
      acc_key_q    <= acc_key_d;
      acc_enc_q    <= acc_enc_d;
      m_data_q     <= m_data_d;
      byte_count_q <= byte_count_d;
    end
  end

  // storage needs no reset: count_q alone decides which entries are live
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s_data;
  end

`ifdef CRS_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      tmr_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      tmr_q         <= tmr_d;
      timeout_err_q <= timeout_err_d;
    end
  end
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign acc_data_in = acc_data_q;
  assign acc_key     = acc_key_q;
  assign acc_encrypt = acc_enc_q;
  assign acc_start   = (state_q == ST_ISSUE);
  assign m_valid     = (state_q == ST_OUTPUT);
  assign m_data      = m_data_q;
  assign byte_count  = byte_count_q;

endmodule

// File: tb/tb_crypto_request_sequencer.sv
// Directed self-checking bench for crypto_request_sequencer with a 3-cycle XOR accelerator model.
// Scenario 6 checks the abort timer when CRS_TIMEOUT_EN is defined, otherwise the indefinite wait.
module tb_crypto_request_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic [7:0]  key;
  logic        encrypt;
  logic [7:0]  acc_data_in;
  logic [7:0]  acc_key;
  logic        acc_encrypt;
  logic        acc_start;
  logic [7:0]  acc_data_out;
  logic        acc_done;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic [15:0] byte_count;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  crypto_request_sequencer #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .key(key), .encrypt(encrypt),
    .acc_data_in(acc_data_in), .acc_key(acc_key), .acc_encrypt(acc_encrypt),
    .acc_start(acc_start), .acc_data_out(acc_data_out), .acc_done(acc_done),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .byte_count(byte_count), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // accelerator: done one cycle, 3 cycles after start; result = data ^ key read at done time
  logic acc_stuck = 1'b0;
  logic acc_enc_seen = 1'b0;
  int   acc_cnt = 0;
  int   starts = 0;

  always @(posedge clk) begin
    if (acc_start === 1'b1) starts++;
  end

  always @(posedge clk) begin
    if (rst) begin
      acc_cnt      <= 0;
      acc_done     <= 1'b0;
      acc_data_out <= 8'h00;
    end else if (acc_start && !acc_stuck) begin
      acc_cnt  <= 3;
      acc_done <= 1'b0;
    end else if (acc_cnt == 1) begin
      acc_cnt      <= 0;
      acc_done     <= 1'b1;
      acc_data_out <= acc_data_in ^ acc_key;
      acc_enc_seen <= acc_encrypt;
    end else if (acc_cnt != 0) begin
      acc_cnt <= acc_cnt - 1;
    end else begin
      acc_done <= 1'b0;
    end
  end

  task automatic push_byte(input logic [7:0] b);
    int n;
    n = 0;
    s_data  = b;
    s_valid = 1'b1;
    while (!s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      checks++;
      errors++;
      $display("FAIL push_%h: s_ready=%b, expected 1 within 200 cycles", b, s_ready);
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic get_result(input logic [7:0] exp, input string name, output int waited);
    waited = 0;
    while (!m_valid && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (m_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s: m_valid=%b, expected 1 within 200 cycles", name, m_valid);
    end else begin
      checks++;
      if (m_data !== exp) begin
        errors++;
        $display("FAIL %s: m_data=%h, expected %h", name, m_data, exp);
      end
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({s_ready, m_valid, acc_start, timeout_err} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_flags: s_ready,m_valid,acc_start,timeout_err=%b, expected 1000",
               {s_ready, m_valid, acc_start, timeout_err});
    end
    checks++;
    if ({acc_data_in, acc_key, acc_encrypt, m_data, byte_count} !== 41'd0) begin
      errors++;
      $display("FAIL reset_data: acc_data_in=%h acc_key=%h acc_encrypt=%b m_data=%h byte_count=%h, expected all 0",
               acc_data_in, acc_key, acc_encrypt, m_data, byte_count);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_encrypt();
    int s0, w;
    s0 = starts;
    key = 8'h3C;
    encrypt = 1'b1;
    push_byte(8'hA5);
    get_result(8'h99, "encrypt_a5", w);
    checks++;
    if (w !== 7) begin
      errors++;
      $display("FAIL encrypt_latency: %0d cycles from push to m_valid, expected 7", w);
    end
    checks++;
    if (starts - s0 !== 1) begin
      errors++;
      $display("FAIL encrypt_starts: %0d acc_start cycles, expected 1", starts - s0);
    end
    checks++;
    if (acc_enc_seen !== 1'b1) begin
      errors++;
      $display("FAIL encrypt_mode: acc_encrypt=%b at done, expected 1", acc_enc_seen);
    end
    checks++;
    if (byte_count !== 16'd1) begin
      errors++;
      $display("FAIL encrypt_count: byte_count=%0d, expected 1", byte_count);
    end
  endtask

  task automatic test_decrypt_key_change();
    int n, w;
    key = 8'h3C;
    encrypt = 1'b0;
    push_byte(8'h99);
    n = 0;
    while (!acc_start && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (acc_start !== 1'b1) begin
      errors++;
      $display("FAIL decrypt_start: acc_start=%b, expected 1 within 20 cycles", acc_start);
    end
    // in-flight byte must keep the key and mode captured at issue
    key = 8'hFF;
    encrypt = 1'b1;
    get_result(8'hA5, "decrypt_99", w);
    checks++;
    if (acc_enc_seen !== 1'b0) begin
      errors++;
      $display("FAIL decrypt_mode: acc_encrypt=%b at done, expected 0", acc_enc_seen);
    end
    checks++;
    if (byte_count !== 16'd2) begin
      errors++;
      $display("FAIL decrypt_count: byte_count=%0d, expected 2", byte_count);
    end
  endtask

  task automatic test_bypass_order();
    int s0, w;
    s0 = starts;
    key = 8'h55;
    encrypt = 1'b1;
    push_byte(8'h00);
    push_byte(8'hFF);
    w = 0;
    while (!m_valid && w < 50) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (starts - s0 !== 0) begin
      errors++;
      $display("FAIL bypass_starts: %0d acc_start cycles for zero byte, expected 0", starts - s0);
    end
    get_result(8'h00, "bypass_00", w);
    get_result(8'hAA, "bypass_ff", w);
    checks++;
    if (starts - s0 !== 1) begin
      errors++;
      $display("FAIL bypass_starts2: %0d acc_start cycles, expected 1", starts - s0);
    end
    checks++;
    if (byte_count !== 16'd4) begin
      errors++;
      $display("FAIL bypass_count: byte_count=%0d, expected 4", byte_count);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] bytes [5];
    logic [7:0] res;
    int w;
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44; bytes[4] = 8'h55;
    key = 8'h0F;
    encrypt = 1'b1;
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_byte(bytes[i]);
    checks++;
    if (s_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_full: s_ready=%b with FIFO full, expected 0", s_ready);
    end
    s_data  = 8'h66;
    s_valid = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (s_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_hold: s_ready=%b while stalled, expected 0", s_ready);
    end
    s_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      res = bytes[i] ^ 8'h0F;
      get_result(res, $sformatf("bp_out%0d", i), w);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_extra: m_valid=%b after draining, expected 0", m_valid);
    end
    checks++;
    if (byte_count !== 16'd9) begin
      errors++;
      $display("FAIL bp_count: byte_count=%0d, expected 9", byte_count);
    end
  endtask

  task automatic test_reset_mid_op();
    int s0;
    s0 = starts;
    acc_stuck = 1'b1;
    key = 8'h01;
    push_byte(8'h01);
    push_byte(8'h02);
    push_byte(8'h03);
    repeat (2) @(negedge clk);
    checks++;
    if (starts - s0 !== 1 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_pre: starts=%0d m_valid=%b, expected 1 and 0", starts - s0, m_valid);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({m_valid, acc_start, s_ready} !== 3'b001 || byte_count !== 16'd0) begin
      errors++;
      $display("FAIL midrst_state: m_valid,acc_start,s_ready=%b byte_count=%0d, expected 001 and 0",
               {m_valid, acc_start, s_ready}, byte_count);
    end
    rst = 1'b0;
    acc_stuck = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (m_valid !== 1'b0 || starts - s0 !== 1) begin
      errors++;
      $display("FAIL midrst_flush: m_valid=%b starts=%0d, expected 0 and 1 (queue discarded)",
               m_valid, starts - s0);
    end
  endtask

  task automatic test_timeout();
    int n, s0, w;
    s0 = starts;
    acc_stuck = 1'b1;
    key = 8'h01;
    push_byte(8'h77);
    n = 0;
    while (!acc_start && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (acc_start !== 1'b1) begin
      errors++;
      $display("FAIL to_start: acc_start=%b, expected 1 within 20 cycles", acc_start);
    end
`ifdef CRS_TIMEOUT_EN
    repeat (16) @(negedge clk);
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL to_early: timeout_err=%b after 15 WAIT_DONE cycles, expected 0", timeout_err);
    end
    @(negedge clk);
    checks++;
    if (timeout_err !== 1'b1 || m_valid !== 1'b0 || byte_count !== 16'd0) begin
      errors++;
      $display("FAIL to_abort: timeout_err=%b m_valid=%b byte_count=%0d, expected 1 0 0",
               timeout_err, m_valid, byte_count);
    end
    acc_stuck = 1'b0;
    push_byte(8'h10);
    get_result(8'h11, "to_next", w);
    checks++;
    if (timeout_err !== 1'b1 || byte_count !== 16'd1) begin
      errors++;
      $display("FAIL to_sticky: timeout_err=%b byte_count=%0d, expected 1 and 1", timeout_err, byte_count);
    end
`else
    repeat (40) @(negedge clk);
    checks++;
    if (timeout_err !== 1'b0 || m_valid !== 1'b0 || starts - s0 !== 1) begin
      errors++;
      $display("FAIL to_wait: timeout_err=%b m_valid=%b starts=%0d, expected 0 0 1",
               timeout_err, m_valid, starts - s0);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    acc_stuck = 1'b0;
    push_byte(8'h10);
    get_result(8'h11, "to_next", w);
    checks++;
    if (byte_count !== 16'd1) begin
      errors++;
      $display("FAIL to_count: byte_count=%0d, expected 1", byte_count);
    end
`endif
  endtask

  initial begin
    rst = 1'b1;
    s_valid = 1'b0;
    s_data = 8'h00;
    key = 8'h00;
    encrypt = 1'b0;
    m_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_encrypt();
    test_decrypt_key_change();
    test_bypass_order();
    test_backpressure();
    test_reset_mid_op();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
